fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction fetch queue between the IF and ID stages of the pipelined RISC-V core. It decouples fetch from decode: IF pushes {pc, instr} pairs and ID pops them under a valid/ready handshake, so a stalled decode no longer loses instructions. On a taken branch, a single-cycle flush discards everything in flight. When the queue is empty it presents a canonical NOP bubble to decode.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- XLEN, 32, PC width in bits
- NOP, 32'h0000_0013, instruction word presented on deq_instr when deq_valid = 0 (addi x0,x0,0)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  branch redirect; discards all entries at the next edge
- enq_valid  in  1  IF offers an entry
- enq_ready  out  1  queue can accept an entry (= not full)
- enq_pc  in  XLEN  PC of the offered instruction
- enq_instr  in  32  fetched instruction word
- deq_valid  out  1  head entry is valid
- deq_ready  in  1  ID consumes the head this cycle
- deq_pc  out  XLEN  head PC; 0 when empty
- deq_pc_plus4  out  XLEN  deq_pc + 4 mod 2^XLEN; 4 when empty
- deq_instr  out  32  head instruction; NOP when empty
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: circular buffer of DEPTH entries {pc, instr}. Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty: pointers are equal.
  - full: low bits equal and MSBs differ.
- enq fires when enq_valid & enq_ready. The entry is written at wr_ptr, and wr_ptr increments.
- deq fires when deq_valid & deq_ready. rd_ptr increments.
- enq_ready = !full. It is purely combinational from state and does not depend on deq_ready, so there is no full-queue pass-through.
- deq_valid = !empty. Head outputs are read combinationally from the entry at rd_ptr.
- When empty, deq_pc = 0, deq_pc_plus4 = 4 and deq_instr = NOP. Contents of stale entries must never appear on the outputs.
- count updates:
  - count' = count + enq − deq.
  - Simultaneous enq and deq leaves count unchanged, and both pointers advance.
- Flush has priority over enq and deq in the same cycle: both pointers reset to 0 and count becomes 0. The entry offered that cycle is dropped; IF re-fetches from the redirect target.
- Reset (asynchronous) has the same effect as flush and also applies mid-operation. Entry storage is not required to reset.
- deq_valid, deq_ready and enq_valid may all toggle freely. There is no requirement that valid be held until ready.

## Timing
- Latency: an entry enqueued at edge N is visible on the deq outputs after edge N. There is no same-cycle empty bypass.
- Throughput: one enq and one deq per cycle sustained when 0 < count < DEPTH.
- Full: enq_ready = 0 throughout the cycle. A deq in that cycle raises enq_ready from the next cycle.
- Empty: deq_valid = 0. An enq in that cycle raises deq_valid from the next cycle.
- Flush asserted in cycle N: after edge N, count = 0, deq_valid = 0 and enq_ready = 1. Outputs are unaffected during cycle N itself.
- Reset values: enq_ready = 1, deq_valid = 0, count = 0, deq_pc = 0, deq_pc_plus4 = 4, deq_instr = NOP.
- Pointer wrap: after DEPTH enqueues, wr_ptr's low bits return to 0 and its MSB toggles. Ordering must hold across any number of wraps.

## Test plan
- Fill to full with DEPTH=4, holding deq_ready = 0:
  - Stimulus: enq pc = 0x0, 0x4, 0x8, 0xC with instrs 0x11..0x14, then offer 0x10.
  - Required: count = 4, enq_ready = 0, and 0x10 is not accepted.
  - Drain: entries pop in order with deq_pc_plus4 = pc + 4. The bubble after the last entry shows NOP with deq_valid = 0.
- Streaming: enq and deq active every cycle for 20 cycles starting at pc = 0x100.
  - Required: count stays at 1, output order is intact across ≥ 4 pointer wraps, and no entry is dropped or duplicated.
- Flush priority: with count = 3, assert flush together with enq_valid = 1 and deq_ready = 1.
  - Required: next cycle count = 0, deq_valid = 0, deq_instr = 0x00000013, and the enqueued entry is lost.
- Asynchronous reset mid-stream: pulse reset between clock edges with count = 2.
  - Required: outputs take their reset values before the next edge. A subsequent enq at pc = 0x200 is output first.
- Full with simultaneous deq: at count = 4, deq_ready = 1 and enq_valid = 1.
  - Required: only the deq fires (count = 3), and enq_ready = 1 in the next cycle.
- PC wrap with XLEN = 32: enq pc = 0xFFFF_FFFC.
  - Required: deq_pc_plus4 = 0x0000_0000.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - IF-to-ID instruction fetch queue with single-cycle flush and NOP bubble.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     enq_valid_i,
    output logic                     enq_ready_o,
    input  logic [XLEN-1:0]          enq_pc_i,
    input  logic [31:0]              enq_instr_i,
    output logic                     deq_valid_o,
    input  logic                     deq_ready_i,
    output logic [XLEN-1:0]          deq_pc_o,
    output logic [XLEN-1:0]          deq_pc_plus4_o,
    output logic [31:0]              deq_instr_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0]  pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];

    logic empty, full, enq_fire, deq_fire;

    // Extra MSB on each pointer distinguishes full from empty when the low bits match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign enq_fire = enq_valid_i && !full;
    assign deq_fire = deq_ready_i && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (enq_fire) wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq_fire) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; empty-masking below keeps stale words off the outputs.
    always_ff @(posedge clk_i) begin
        if (enq_fire && !flush_i) begin
            pc_mem_q[wr_ptr_q[AW-1:0]]    <= enq_pc_i;
            instr_mem_q[wr_ptr_q[AW-1:0]] <= enq_instr_i;
        end
    end

    assign enq_ready_o    = !full;
    assign deq_valid_o    = !empty;
    assign deq_pc_o       = empty ? '0  : pc_mem_q[rd_ptr_q[AW-1:0]];
    assign deq_instr_o    = empty ? NOP : instr_mem_q[rd_ptr_q[AW-1:0]];
    assign deq_pc_plus4_o = deq_pc_o + XLEN'(4);
    assign count_o        = wr_ptr_q - rd_ptr_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, flush, enq_valid, deq_ready;
    logic [31:0] enq_pc, enq_instr;
    logic        enq_ready, deq_valid;
    logic [31:0] deq_pc, deq_pc_plus4, deq_instr;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    logic [63:0] mq[$];

    fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .NOP(NOP)) dut (
        .clk_i(clk), .reset_i(reset), .flush_i(flush),
        .enq_valid_i(enq_valid), .enq_ready_o(enq_ready),
        .enq_pc_i(enq_pc), .enq_instr_i(enq_instr),
        .deq_valid_o(deq_valid), .deq_ready_i(deq_ready),
        .deq_pc_o(deq_pc), .deq_pc_plus4_o(deq_pc_plus4),
        .deq_instr_o(deq_instr), .count_o(count)
    );

    always #5 clk = ~clk;

    // Drives one cycle from a falling edge and advances the model by the queue rules.
    task automatic drive_cycle(input logic ev, input logic [31:0] pc, input logic [31:0] ins,
                               input logic dr, input logic fl);
        int  n;
        bit  do_enq, do_deq;
        logic [63:0] dummy;
        enq_valid = ev; enq_pc = pc; enq_instr = ins; deq_ready = dr; flush = fl;
        n = mq.size();
        do_deq = dr && (n > 0);
        do_enq = ev && (n < DEPTH);
        @(posedge clk);
        if (fl) mq.delete();
        else begin
            if (do_deq) dummy = mq.pop_front();
            if (do_enq) mq.push_back({pc, ins});
        end
        @(negedge clk);
        enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 0; enq_valid = 0; deq_ready = 0; enq_pc = 0; enq_instr = 0;
        repeat (2) @(negedge clk);
        checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL reset_deq_valid got=%b exp=0", deq_valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (deq_pc !== 32'h0) begin failures++; $display("FAIL reset_deq_pc got=%h exp=0", deq_pc); end
        checks++; if (deq_pc_plus4 !== 32'h4) begin failures++; $display("FAIL reset_plus4 got=%h exp=4", deq_pc_plus4); end
        checks++; if (deq_instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", deq_instr, NOP); end
        reset = 1'b0;
        mq.delete();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) drive_cycle(1, 32'(i * 4), 32'h11 + 32'(i), 0, 0);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
        checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL full_enq_ready got=%b exp=0", enq_ready); end
        drive_cycle(1, 32'h10, 32'h15, 0, 0);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_reject_count got=%0d exp=4", count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (deq_valid !== 1'b1 || deq_pc !== 32'(i * 4) || deq_instr !== 32'h11 + 32'(i)
                          || deq_pc_plus4 !== 32'(i * 4 + 4)) begin
                failures++; $display("FAIL drain_%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", i, deq_valid, deq_pc,
                                     deq_instr, deq_pc_plus4, 32'(i * 4), 32'h11 + 32'(i), 32'(i * 4 + 4));
            end
            drive_cycle(0, 0, 0, 1, 0);
        end
        checks++; if (deq_valid !== 1'b0 || deq_instr !== NOP || deq_pc !== 0 || deq_pc_plus4 !== 32'h4) begin
            failures++; $display("FAIL drain_bubble got=%b/%h/%h/%h exp=0/00000013/0/4", deq_valid, deq_instr, deq_pc, deq_pc_plus4);
        end
    endtask

    task automatic test_streaming();
        int errs = 0;
        drive_cycle(1, 32'h100, 32'hA000, 0, 0);
        for (int i = 0; i < 20; i++) begin
            if (count !== 3'd1 || deq_pc !== 32'h100 + 32'(4 * i) || deq_instr !== 32'hA000 + 32'(i)) begin
                errs++; $display("FAIL stream_%0d got=%0d/%h/%h exp=1/%h/%h", i, count, deq_pc, deq_instr,
                                 32'h100 + 32'(4 * i), 32'hA000 + 32'(i));
            end
            drive_cycle(1, 32'h104 + 32'(4 * i), 32'hA001 + 32'(i), 1, 0);
        end
        checks++; if (errs != 0) failures++;
        checks++; if (count !== 3'd1 || deq_pc !== 32'h150) begin
            failures++; $display("FAIL stream_tail got=%0d/%h exp=1/00000150", count, deq_pc);
        end
        drive_cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_flush_priority();
        for (int i = 0; i < 3; i++) drive_cycle(1, 32'h300 + 32'(4 * i), 32'hB0 + 32'(i), 0, 0);
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
        drive_cycle(1, 32'h30C, 32'hB3, 1, 1);
        checks++; if (count !== 3'd0 || deq_valid !== 1'b0 || deq_instr !== NOP || enq_ready !== 1'b1) begin
            failures++; $display("FAIL flush_post got=%0d/%b/%h/%b exp=0/0/00000013/1", count, deq_valid, deq_instr, enq_ready);
        end
        drive_cycle(0, 0, 0, 0, 0);
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL flush_lost got=%b exp=0", deq_valid); end
    endtask

    task automatic test_async_reset();
        drive_cycle(1, 32'h400, 32'hC0, 0, 0);
        drive_cycle(1, 32'h404, 32'hC1, 0, 0);
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL areset_pre got=%0d exp=2", count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (count !== 3'd0 || deq_valid !== 1'b0 || enq_ready !== 1'b1 || deq_pc !== 0
                      || deq_pc_plus4 !== 32'h4 || deq_instr !== NOP) begin
            failures++; $display("FAIL areset_now got=%0d/%b/%b/%h/%h/%h exp=0/0/1/0/4/00000013",
                                 count, deq_valid, enq_ready, deq_pc, deq_pc_plus4, deq_instr);
        end
        #1 reset = 1'b0;
        mq.delete();
        @(negedge clk);
        drive_cycle(1, 32'h200, 32'hD0, 0, 0);
        checks++; if (deq_valid !== 1'b1 || deq_pc !== 32'h200 || deq_instr !== 32'hD0) begin
            failures++; $display("FAIL areset_first got=%b/%h/%h exp=1/00000200/000000d0", deq_valid, deq_pc, deq_instr);
        end
        drive_cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_full_deq();
        for (int i = 0; i < 4; i++) drive_cycle(1, 32'h500 + 32'(4 * i), 32'hE0 + 32'(i), 0, 0);
        drive_cycle(1, 32'h510, 32'hE4, 1, 0);
        checks++; if (count !== 3'd3 || enq_ready !== 1'b1 || deq_pc !== 32'h504) begin
            failures++; $display("FAIL full_deq got=%0d/%b/%h exp=3/1/00000504", count, enq_ready, deq_pc);
        end
        drive_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_pc_wrap();
        drive_cycle(1, 32'hFFFF_FFFC, 32'hF0, 0, 0);
        checks++; if (deq_pc !== 32'hFFFF_FFFC || deq_pc_plus4 !== 32'h0) begin
            failures++; $display("FAIL pc_wrap got=%h/%h exp=fffffffc/00000000", deq_pc, deq_pc_plus4);
        end
        drive_cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        int errs = 0;
        logic [31:0] e_pc, e_ins;
        for (int i = 0; i < 400; i++) begin
            e_pc  = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
            e_ins = (mq.size() > 0) ? mq[0][31:0]  : NOP;
            if (deq_valid !== (mq.size() > 0) || enq_ready !== (mq.size() < DEPTH) || count !== 3'(mq.size())
                || deq_pc !== e_pc || deq_instr !== e_ins || deq_pc_plus4 !== e_pc + 32'd4) begin
                errs++;
                $display("FAIL random_%0d got=%b/%b/%0d/%h/%h exp=%b/%b/%0d/%h/%h", i, deq_valid, enq_ready, count,
                         deq_pc, deq_instr, mq.size() > 0, mq.size() < DEPTH, mq.size(), e_pc, e_ins);
            end
            drive_cycle(1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom,
                        1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end
        checks++; if (errs != 0) failures++;
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_fill_drain();
        test_streaming();
        test_flush_priority();
        test_async_reset();
        test_full_deq();
        test_pc_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
